// File: rtl/vga_pkg.sv
// vga_pkg: timing constants and FSM state type shared by the VGA
// transmitter and the sync receiver.
//   VGA_H_* : horizontal segment lengths in pixel clocks (640x480@60 defaults)
//   VGA_V_* : vertical segment lengths in lines
//   VGA_H_TOTAL / VGA_V_TOTAL : full line / frame lengths
//   sync_state_t : receiver lock state
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } sync_state_t;

endpackage

// File: rtl/get_next_coords.sv
// get_next_coords: combinational raster advance. Returns the position that
// follows (x,y) in raster order, wrapping x at FIELD_W-1 and y at FIELD_H-1.
//   x, y           : current position
//   next_x, next_y : following position
module get_next_coords
  import vga_pkg::*;
#(
  parameter int unsigned FIELD_W = VGA_H_TOTAL,
  parameter int unsigned FIELD_H = VGA_V_TOTAL
) (
  input  logic [$clog2(FIELD_W)-1:0] x,
  input  logic [$clog2(FIELD_H)-1:0] y,
  output logic [$clog2(FIELD_W)-1:0] next_x,
  output logic [$clog2(FIELD_H)-1:0] next_y
);

  localparam int unsigned XW = $clog2(FIELD_W);
  localparam int unsigned YW = $clog2(FIELD_H);

  always_comb begin
    next_x = x + XW'(1);
    next_y = y;
    if (x == XW'(FIELD_W - 1)) begin
      next_x = '0;
      if (y == YW'(FIELD_H - 1)) next_y = '0;
      else                       next_y = y + YW'(1);
    end
  end

endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers the transmitter's pixel position from its h/v sync
// pulses, verifies the sync timing and reports lock, position and errors.
//   clk, rst_n        : pixel clock, async active-low reset
//   i_h_sync/i_v_sync : active-low syncs from the transmitter (clk domain)
//   o_locked          : timing verified over a full frame
//   o_pixel_valid     : locked and recovered position inside the active area
//   o_x, o_y          : recovered column/row (0 when not valid)
//   o_frame_start     : one-cycle pulse at recovered (0,0) while locked
//   o_err, o_err_cnt  : violation pulse and saturating count of pulses
// Outputs lag the transmitter's position by exactly one clock.
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT  = VGA_H_FRONT,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BACK   = VGA_H_BACK,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT  = VGA_V_FRONT,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BACK   = VGA_V_BACK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_h_sync,
  input  logic                        i_v_sync,
  output logic                        o_locked,
  output logic                        o_pixel_valid,
  output logic [$clog2(H_ACTIVE)-1:0] o_x,
  output logic [$clog2(V_ACTIVE)-1:0] o_y,
  output logic                        o_frame_start,
  output logic                        o_err,
  output logic [7:0]                  o_err_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);
  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam int unsigned WW = $clog2(2 * H_TOTAL);

  // Positions at which the sync edges are seen; the register value one
  // cycle earlier must be the position just before each of these.
  localparam logic [HW-1:0] H_FALL_X = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_RISE_X = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_FALL_Y = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_RISE_Y = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [WW-1:0] WD_LAST  = WW'(2 * H_TOTAL - 1);

  sync_state_t   state, state_nxt;
  logic [HW-1:0] hc, hc_adv, hc_nxt;
  logic [VW-1:0] vc, vc_adv, vc_nxt;
  logic [WW-1:0] wd, wd_nxt;
  logic          hs_q, vs_q;
  logic          h_fall, h_rise, v_fall, v_rise;
  logic          viol, wd_expire, err_now, valid_nxt;

  get_next_coords #(
    .FIELD_W(H_TOTAL),
    .FIELD_H(V_TOTAL)
  ) u_next (
    .x      (hc),
    .y      (vc),
    .next_x (hc_adv),
    .next_y (vc_adv)
  );

  assign h_fall = hs_q & ~i_h_sync;
  assign h_rise = ~hs_q & i_h_sync;
  assign v_fall = vs_q & ~i_v_sync;
  assign v_rise = ~vs_q & i_v_sync;

  always_comb begin
    hc_nxt = hc_adv;
    vc_nxt = vc_adv;
    if (v_fall) begin
      hc_nxt = '0;
      vc_nxt = V_FALL_Y;
    end else if (h_fall) begin
      hc_nxt = H_FALL_X;
    end
  end

  always_comb begin
    viol = (h_fall && (hc != H_FALL_X - HW'(1)))
        || (h_rise && (hc != H_RISE_X - HW'(1)))
        || (v_fall && ((vc != V_FALL_Y - VW'(1)) || (hc != H_LAST)))
        || (v_rise && ((vc != V_RISE_Y - VW'(1)) || (hc != H_LAST)));
    wd_expire = !h_fall && (wd == WD_LAST);
    wd_nxt    = (h_fall || wd_expire) ? '0 : wd + WW'(1);
  end

  always_comb begin
    state_nxt = state;
    err_now   = 1'b0;
    case (state)
      UNLOCKED: if (v_fall && !wd_expire) state_nxt = ACQUIRE;
      ACQUIRE, LOCKED: begin
        if (viol || wd_expire) begin
          err_now   = 1'b1;
          state_nxt = UNLOCKED;
        end else if (v_fall) begin
          state_nxt = LOCKED;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  // Outputs are computed from next-state values so they line up with hc/vc.
  assign valid_nxt = (state_nxt == LOCKED) && (hc_nxt < HW'(H_ACTIVE))
                  && (vc_nxt < VW'(V_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UNLOCKED;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc            <= '0;
      vc            <= '0;
      wd            <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      o_locked      <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
      o_err_cnt     <= '0;
    end else begin
      hc            <= hc_nxt;
      vc            <= vc_nxt;
      wd            <= wd_nxt;
      hs_q          <= i_h_sync;
      vs_q          <= i_v_sync;
      o_locked      <= (state_nxt == LOCKED);
      o_pixel_valid <= valid_nxt;
      o_x           <= valid_nxt ? hc_nxt[XW-1:0] : '0;
      o_y           <= valid_nxt ? vc_nxt[YW-1:0] : '0;
      o_frame_start <= (state_nxt == LOCKED) && (hc_nxt == '0) && (vc_nxt == '0);
      o_err         <= err_now;
      if (err_now && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule
